fade_pwm_driver_tt: RTL and testbench

//   Consumer end of the fade-level interface: samples the 8-bit fade level and direction

---
 rtl/fade_pwm_driver_tt.sv | 97 +++++++++
 tb/tb_fade_pwm_driver_tt.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fade_pwm_driver_tt.sv
// Fade-level consumer: double-buffered PWM with optional square-law gamma,
// sunrise/sunset event pulses and a sticky level-step protocol monitor.
module fade_pwm_driver_tt #(
    parameter int unsigned PRESCALE = 4,
    parameter bit          GAMMA_EN = 1'b0
) (
    input  logic       clk_i,
    input  logic       rst_n,
    input  logic [7:0] level_i,
    input  logic       direction_i,
    input  logic       clear_err_i,
    output logic       pwm_out_o,
    output logic [7:0] duty_o,
    output logic       sunrise_pulse_o,
    output logic       sunset_pulse_o,
    output logic       step_error_o
);

    localparam int unsigned PrescW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PrescW-1:0] PrescMax = PrescW'(PRESCALE - 1);

    logic [PrescW-1:0] presc_cnt_q, presc_cnt_d;
    logic [7:0]        pwm_cnt_q, pwm_cnt_d;
    logic [7:0]        duty_q, duty_d;
    logic [7:0]        level_q;
    logic              dir_q;
    logic              primed_q;
    logic              pwm_out_q, pwm_out_d;
    logic              sunrise_q, sunrise_d;
    logic              sunset_q, sunset_d;
    logic              step_error_q, step_error_d;

    logic              tick;
    logic [15:0]       gamma_sum;
    logic [7:0]        duty_f;
    logic              step_legal;
    logic              step_viol;

    always_comb begin
        tick        = (presc_cnt_q == PrescMax);
        presc_cnt_d = tick ? '0 : presc_cnt_q + 1'b1;
        pwm_cnt_d   = tick ? pwm_cnt_q + 8'd1 : pwm_cnt_q;

        // Max L*L + 255 = 65280, so 16 bits never overflow.
        gamma_sum = ({8'd0, level_q} * {8'd0, level_q}) + 16'd255;
        duty_f    = GAMMA_EN ? 8'(gamma_sum >> 8) : level_q;

        // New duty only at the period boundary so a period is never torn.
        duty_d    = (tick && (pwm_cnt_q == 8'hFF)) ? duty_f : duty_q;
        pwm_out_d = (pwm_cnt_q < duty_q);

        sunset_d  = primed_q & direction_i & ~dir_q;
        sunrise_d = primed_q & ~direction_i & dir_q;

        // 9-bit compare so 255->0 and 0->255 never look like legal steps.
        step_legal = direction_i ? (({1'b0, level_i} + 9'd1) == {1'b0, level_q})
                                 : ({1'b0, level_i} == ({1'b0, level_q} + 9'd1));
        step_viol  = primed_q && (level_i != level_q) && !step_legal;

        step_error_d = step_error_q;
        if (clear_err_i) step_error_d = 1'b0;
        if (step_viol)   step_error_d = 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            presc_cnt_q  <= '0;
            pwm_cnt_q    <= '0;
            duty_q       <= '0;
            level_q      <= '0;
            dir_q        <= 1'b0;
            primed_q     <= 1'b0;
            pwm_out_q    <= 1'b0;
            sunrise_q    <= 1'b0;
            sunset_q     <= 1'b0;
            step_error_q <= 1'b0;
        end else begin
            presc_cnt_q  <= presc_cnt_d;
            pwm_cnt_q    <= pwm_cnt_d;
            duty_q       <= duty_d;
            level_q      <= level_i;
            dir_q        <= direction_i;
            primed_q     <= 1'b1;
            pwm_out_q    <= pwm_out_d;
            sunrise_q    <= sunrise_d;
            sunset_q     <= sunset_d;
            step_error_q <= step_error_d;
        end
    end

    assign pwm_out_o       = pwm_out_q;
    assign duty_o          = duty_q;
    assign sunrise_pulse_o = sunrise_q;
    assign sunset_pulse_o  = sunset_q;
    assign step_error_o    = step_error_q;

endmodule

// File: tb/tb_fade_pwm_driver_tt.sv
// Bench for fade_pwm_driver_tt: two instances (plain P=1, gamma P=2) driven by the
// same stream and compared every cycle against an edge-count based reference model.
module tb_fade_pwm_driver_tt;

    localparam int PA = 1;
    localparam int PG = 2;
    localparam int HistLen = 8192;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] level = 8'd0;
    logic       direction = 1'b0;
    logic       clear_err = 1'b0;

    logic       pwm_a, rise_a, set_a, err_a;
    logic [7:0] duty_a;
    logic       pwm_g, rise_g, set_g, err_g;
    logic [7:0] duty_g;

    fade_pwm_driver_tt #(.PRESCALE(PA), .GAMMA_EN(1'b0)) dut_a (
        .clk_i(clk), .rst_n(rst_n), .level_i(level), .direction_i(direction),
        .clear_err_i(clear_err), .pwm_out_o(pwm_a), .duty_o(duty_a),
        .sunrise_pulse_o(rise_a), .sunset_pulse_o(set_a), .step_error_o(err_a)
    );

    fade_pwm_driver_tt #(.PRESCALE(PG), .GAMMA_EN(1'b1)) dut_g (
        .clk_i(clk), .rst_n(rst_n), .level_i(level), .direction_i(direction),
        .clear_err_i(clear_err), .pwm_out_o(pwm_g), .duty_o(duty_g),
        .sunrise_pulse_o(rise_g), .sunset_pulse_o(set_g), .step_error_o(err_g)
    );

    always #5 clk = ~clk;

    // History of what was presented before each edge since the last reset release.
    int  n;
    int  lvl_h [HistLen];
    bit  dir_h [HistLen];
    bit  err_h [HistLen];
    int  errors = 0;
    int  checks = 0;

    function automatic int gamma_f(input int l, input bit g);
        return g ? (l * l + 255) / 256 : l;
    endfunction

    // Duty after k edges: latched from the level held before the last full-period boundary.
    function automatic int duty_at(input int k, input int p, input bit g);
        int per = 256 * p;
        int m = (k / per) * per;
        if (m == 0) return 0;
        return gamma_f(lvl_h[m-1], g);
    endfunction

    function automatic int pwm_at(input int k, input int p, input bit g);
        if (k == 0) return 0;
        return ((((k - 1) / p) % 256) < duty_at(k - 1, p, g)) ? 1 : 0;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d (edge %0d)", tag, obs, exp, n);
        end
    endtask

    task automatic step(input int l, input bit d, input bit c);
        bit legal, viol;
        int sset, srise;
        if (n >= HistLen - 2) begin
            $display("FAIL history_overflow: observed=%0d expected<%0d", n, HistLen - 2);
            $fatal(1);
        end
        level = 8'(l);
        direction = d;
        clear_err = c;
        n++;
        lvl_h[n] = l;
        dir_h[n] = d;
        legal = d ? (l == lvl_h[n-1] - 1) : (l == lvl_h[n-1] + 1);
        viol = (n >= 2) && (l != lvl_h[n-1]) && !legal;
        err_h[n] = viol ? 1'b1 : (c ? 1'b0 : err_h[n-1]);
        sset  = ((n >= 2) && d && !dir_h[n-1]) ? 1 : 0;
        srise = ((n >= 2) && !d && dir_h[n-1]) ? 1 : 0;
        @(posedge clk);
        #1;
        check("pwm_a", 32'(pwm_a), 32'(pwm_at(n, PA, 1'b0)));
        check("duty_a", 32'(duty_a), 32'(duty_at(n, PA, 1'b0)));
        check("sunset_a", 32'(set_a), 32'(sset));
        check("sunrise_a", 32'(rise_a), 32'(srise));
        check("err_a", 32'(err_a), 32'(err_h[n]));
        check("pwm_g", 32'(pwm_g), 32'(pwm_at(n, PG, 1'b1)));
        check("duty_g", 32'(duty_g), 32'(duty_at(n, PG, 1'b1)));
        check("sunset_g", 32'(set_g), 32'(sset));
        check("sunrise_g", 32'(rise_g), 32'(srise));
        check("err_g", 32'(err_g), 32'(err_h[n]));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("rst_pwm_a", 32'(pwm_a), 32'd0);
        check("rst_duty_a", 32'(duty_a), 32'd0);
        check("rst_pulses_a", 32'({rise_a, set_a}), 32'd0);
        check("rst_err_a", 32'(err_a), 32'd0);
        check("rst_pwm_g", 32'(pwm_g), 32'd0);
        check("rst_duty_g", 32'(duty_g), 32'd0);
        check("rst_pulses_g", 32'({rise_g, set_g}), 32'd0);
        check("rst_err_g", 32'(err_g), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        lvl_h[0] = 0;
        dir_h[0] = 1'b0;
        err_h[0] = 1'b0;
    endtask

    initial begin
        int hi;
        int cur;
        bit cdir;
        bit found;
        int gl [4];
        int ge [4];
        gl = '{0, 1, 128, 255};
        ge = '{0, 1, 64, 255};
        n = 0;

        #3;
        do_reset();

        // Level 128 held, direction already 1 at release: no pulses, 128/256 high.
        for (int i = 0; i < 256; i++) step(128, 1'b1, 1'b0);
        check("duty_128", 32'(duty_a), 32'd128);
        hi = 0;
        for (int i = 0; i < 256; i++) begin
            step(128, 1'b1, 1'b0);
            hi += int'(pwm_a);
        end
        check("highs_128", 32'(hi), 32'd128);

        // Mid-period change 64 -> 192 must not disturb the running period.
        step(64, 1'b1, 1'b0);
        step(64, 1'b1, 1'b0);
        while (n % 256 != 0) step(64, 1'b1, 1'b0);
        check("duty_64", 32'(duty_a), 32'd64);
        hi = 0;
        for (int i = 0; i < 256; i++) begin
            step((i < 128) ? 64 : 192, 1'b1, 1'b0);
            hi += int'(pwm_a);
            if (i == 254) check("duty_hold_64", 32'(duty_a), 32'd64);
        end
        check("highs_64", 32'(hi), 32'd64);
        check("duty_192", 32'(duty_a), 32'd192);
        hi = 0;
        for (int i = 0; i < 256; i++) begin
            step(192, 1'b1, 1'b0);
            hi += int'(pwm_a);
        end
        check("highs_192", 32'(hi), 32'd192);

        // Direction reversals with level held.
        step(192, 1'b0, 1'b1);
        check("sunrise_on", 32'(rise_a), 32'd1);
        step(192, 1'b0, 1'b0);
        check("sunrise_off", 32'(rise_a), 32'd0);
        step(192, 1'b1, 1'b0);
        check("sunset_on", 32'(set_a), 32'd1);
        step(192, 1'b1, 1'b0);
        check("sunset_off", 32'(set_a), 32'd0);

        // Step monitor: skip, sticky, clear, violation beats clear, legal ramp.
        step(10, 1'b0, 1'b1);
        step(10, 1'b0, 1'b1);
        check("err_cleared", 32'(err_a), 32'd0);
        step(12, 1'b0, 1'b0);
        check("err_skip", 32'(err_a), 32'd1);
        step(12, 1'b0, 1'b0);
        check("err_sticky", 32'(err_a), 32'd1);
        step(12, 1'b0, 1'b1);
        check("err_clear", 32'(err_a), 32'd0);
        step(10, 1'b0, 1'b1);
        check("err_viol_wins", 32'(err_a), 32'd1);
        step(10, 1'b0, 1'b1);
        step(11, 1'b0, 1'b0);
        step(12, 1'b0, 1'b0);
        check("err_ramp_ok", 32'(err_a), 32'd0);

        // Gamma instance: duty after a full period with each level held.
        for (int j = 0; j < 4; j++) begin
            for (int i = 0; i < 600; i++) step(gl[j], 1'b1, 1'b0);
            check("gamma_duty", 32'(duty_g), 32'(ge[j]));
        end

        // Random mix of legal ramps, holds, reversals, illegal jumps and clears.
        cur = 255;
        cdir = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 5) begin
                cdir = ~cdir;
            end else if (r < 8) begin
                cur = int'($urandom_range(0, 255));
            end else if (r < 60) begin
                if (!cdir && cur < 255) cur = cur + 1;
                else if (cdir && cur > 0) cur = cur - 1;
                else cdir = ~cdir;
            end
            step(cur, cdir, ($urandom_range(0, 15) == 0));
        end

        // Asynchronous reset while the output is high, then restart from count 0.
        found = 1'b0;
        for (int i = 0; i < 600 && !found; i++) begin
            step(200, 1'b1, 1'b0);
            if (pwm_a) found = 1'b1;
        end
        check("pwm_high_before_reset", 32'(found), 32'd1);
        #2;
        do_reset();
        hi = 0;
        for (int i = 0; i < 256; i++) begin
            step(200, 1'b0, 1'b0);
            hi += int'(pwm_a);
        end
        check("highs_after_reset", 32'(hi), 32'd0);
        hi = 0;
        for (int i = 0; i < 256; i++) begin
            step(200, 1'b0, 1'b0);
            hi += int'(pwm_a);
        end
        check("highs_200", 32'(hi), 32'd200);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
